// File: rtl/power_frame_buffer.sv
// Ping-pong frame buffer for the power-spectrum stream. One bank fills while the other is read.
// Tracks the peak bin as the frame streams in.
module power_frame_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BINS   = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_BINS)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] power_data_in,
  input  logic                  power_valid_in,
  input  logic                  power_last_in,
  output logic                  power_ready_out,
  input  logic                  rd_lock_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  frame_valid_out,
  output logic [ADDR_WIDTH:0]   frame_len_out,
  output logic [ADDR_WIDTH-1:0] peak_bin_out,
  output logic [DATA_WIDTH-1:0] peak_value_out,
  output logic [15:0]           frame_count_out,
  output logic                  overrun_out
);

  localparam int unsigned LenW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StFill, StDrain, StHold} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_wsel;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [DATA_WIDTH-1:0] r_run_max;
  logic [ADDR_WIDTH-1:0] r_run_bin;
  logic [LenW-1:0]       r_len;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_frame_valid;
  logic [LenW-1:0]       r_frame_len;
  logic [ADDR_WIDTH-1:0] r_peak_bin;
  logic [DATA_WIDTH-1:0] r_peak_value;
  logic [15:0]           r_frame_count;
  logic                  r_overrun;

  // Both banks live in one array; the bank select is the address MSB.
  logic [DATA_WIDTH-1:0] r_mem [2*NUM_BINS];

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_fill_acc;
  logic                  w_at_end;
  logic                  w_done;
  logic                  w_swap;
  logic                  w_upd;
  logic [DATA_WIDTH-1:0] w_nxt_max;
  logic [ADDR_WIDTH-1:0] w_nxt_bin;
  logic [LenW-1:0]       w_fin_len;

  assign w_ready    = (r_state != StHold);
  assign w_accept   = power_valid_in & w_ready;
  assign w_fill_acc = w_accept & (r_state == StFill);
  assign w_at_end   = (r_wptr == ADDR_WIDTH'(NUM_BINS - 1));
  assign w_done     = w_accept & power_last_in;
  assign w_swap     = ~rd_lock_in & (w_done | (r_state == StHold));

  // First beat of a frame always loads the peak; ties keep the earlier bin.
  assign w_upd     = w_fill_acc & ((r_wptr == '0) | (power_data_in > r_run_max));
  assign w_nxt_max = w_upd ? power_data_in : r_run_max;
  assign w_nxt_bin = w_upd ? r_wptr : r_run_bin;

  always_comb begin
    w_fin_len = r_len;
    case (r_state)
      StFill:  w_fin_len = {1'b0, r_wptr} + LenW'(1);
      StDrain: w_fin_len = LenW'(NUM_BINS);
      default: w_fin_len = r_len;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StFill: begin
        if (w_accept) begin
          if (power_last_in) w_state_nxt = rd_lock_in ? StHold : StFill;
          else if (w_at_end) w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_accept && power_last_in) w_state_nxt = rd_lock_in ? StHold : StFill;
      end
      StHold: begin
        if (!rd_lock_in) w_state_nxt = StFill;
      end
      default: w_state_nxt = StFill;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_fill_acc) r_mem[{r_wsel, r_wptr}] <= power_data_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= StFill;
      r_wsel        <= 1'b0;
      r_wptr        <= '0;
      r_run_max     <= '0;
      r_run_bin     <= '0;
      r_len         <= '0;
      r_rd_data     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_len   <= '0;
      r_peak_bin    <= '0;
      r_peak_value  <= '0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_data     <= r_mem[{~r_wsel, rd_addr_in}];
      r_frame_valid <= w_swap;
      r_run_max     <= w_nxt_max;
      r_run_bin     <= w_nxt_bin;
      if (w_fill_acc) r_wptr <= r_wptr + ADDR_WIDTH'(1);
      if (w_fill_acc && !power_last_in && w_at_end) r_overrun <= 1'b1;
      if (w_done) begin
        r_wptr <= '0;
        r_len  <= w_fin_len;
      end
      if (w_swap) begin
        r_wsel        <= ~r_wsel;
        r_frame_len   <= w_fin_len;
        r_peak_bin    <= w_nxt_bin;
        r_peak_value  <= w_nxt_max;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign power_ready_out = w_ready;
  assign rd_data_out     = r_rd_data;
  assign frame_valid_out = r_frame_valid;
  assign frame_len_out   = r_frame_len;
  assign peak_bin_out    = r_peak_bin;
  assign peak_value_out  = r_peak_value;
  assign frame_count_out = r_frame_count;
  assign overrun_out     = r_overrun;

endmodule

// File: tb/tb_power_frame_buffer.sv
// Directed bench for power_frame_buffer with NUM_BINS=16.
module tb_power_frame_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned NB = 16;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data;
  logic          valid;
  logic          last;
  logic          ready;
  logic          lock;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          fvalid;
  logic [AW:0]   flen;
  logic [AW-1:0] pbin;
  logic [DW-1:0] pval;
  logic [15:0]   fcount;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  power_frame_buffer #(
    .DATA_WIDTH(DW),
    .NUM_BINS  (NB),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .power_data_in  (data),
    .power_valid_in (valid),
    .power_last_in  (last),
    .power_ready_out(ready),
    .rd_lock_in     (lock),
    .rd_addr_in     (rd_addr),
    .rd_data_out    (rd_data),
    .frame_valid_out(fvalid),
    .frame_len_out  (flen),
    .peak_bin_out   (pbin),
    .peak_value_out (pval),
    .frame_count_out(fcount),
    .overrun_out    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    data  = '0;
    lock  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one beat at a negedge; it is taken at the following posedge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    valid = 1'b1;
    data  = d;
    last  = l;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b1;
    valid   = 1'b0;
    last    = 1'b0;
    data    = '0;
    lock    = 1'b0;
    rd_addr = '0;

    // 1: reset state, then 8-beat frame
    do_reset();
    check("rst_ready", ready, 1);
    check("rst_fvalid", fvalid, 0);
    check("rst_len", flen, 0);
    check("rst_pbin", pbin, 0);
    check("rst_pval", pval, 0);
    check("rst_count", fcount, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rddata", rd_data, 0);
    for (int i = 0; i < 8; i++) begin
      check("t1_ready", ready, 1);
      send(DW'(10 * i), i == 7);
    end
    valid = 1'b0;
    check("t1_fvalid", fvalid, 1);
    check("t1_len", flen, 8);
    check("t1_pbin", pbin, 7);
    check("t1_pval", pval, 70);
    check("t1_count", fcount, 1);
    rd_addr = 4'd3;
    @(negedge clk);
    check("t1_fvalid_drop", fvalid, 0);
    check("t1_rd3", rd_data, 30);

    // 2: back-to-back 4-beat frames
    do_reset();
    send(5, 0); check("t2_ready", ready, 1);
    send(9, 0); check("t2_ready", ready, 1);
    send(9, 0); check("t2_ready", ready, 1);
    send(1, 1); check("t2_ready", ready, 1);
    check("t2_f1_fvalid", fvalid, 1);
    check("t2_f1_pbin", pbin, 1);
    check("t2_f1_pval", pval, 9);
    check("t2_f1_len", flen, 4);
    send(2, 0); check("t2_ready", ready, 1);
    check("t2_f1_fvalid_drop", fvalid, 0);
    send(2, 0); check("t2_ready", ready, 1);
    send(2, 0); check("t2_ready", ready, 1);
    send(2, 1); check("t2_ready", ready, 1);
    valid = 1'b0;
    check("t2_f2_fvalid", fvalid, 1);
    check("t2_f2_pbin", pbin, 0);
    check("t2_f2_pval", pval, 2);
    check("t2_count", fcount, 2);
    rd_addr = 4'd1;
    @(negedge clk);
    check("t2_rd1", rd_data, 2);

    // 3: overrun, 20 beats into 16 bins
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(DW'(i), i == 19);
      if (i == 15) check("t3_overrun_early", overrun, 1);
      if (i < 19) check("t3_no_fvalid", fvalid, 0);
    end
    valid = 1'b0;
    check("t3_fvalid", fvalid, 1);
    check("t3_overrun", overrun, 1);
    check("t3_len", flen, 16);
    check("t3_pval", pval, 15);
    check("t3_pbin", pbin, 15);
    check("t3_count", fcount, 1);
    rd_addr = 4'd0;
    @(negedge clk);
    check("t3_rd0", rd_data, 0);
    rd_addr = 4'd15;
    @(negedge clk);
    check("t3_rd15", rd_data, 15);
    send(3, 1);
    valid = 1'b0;
    check("t3_overrun_sticky", overrun, 1);
    check("t3_len_next", flen, 1);

    // 4: lock holds the swap
    do_reset();
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    valid   = 1'b0;
    rd_addr = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("t4_rd_before", rd_data, 1);
    lock = 1'b1;
    send(11, 0); send(12, 0); send(13, 0); send(14, 1);
    valid = 1'b0;
    check("t4_hold_ready", ready, 0);
    check("t4_hold_fvalid", fvalid, 0);
    check("t4_hold_count", fcount, 1);
    check("t4_hold_rd", rd_data, 1);
    @(negedge clk);
    check("t4_hold_ready2", ready, 0);
    check("t4_hold_fvalid2", fvalid, 0);
    check("t4_hold_pval", pval, 4);
    lock = 1'b0;
    @(negedge clk);
    check("t4_fvalid", fvalid, 1);
    check("t4_ready", ready, 1);
    check("t4_count", fcount, 2);
    check("t4_pval", pval, 14);
    check("t4_pbin", pbin, 3);
    check("t4_len", flen, 4);
    check("t4_rd_old", rd_data, 1);
    @(negedge clk);
    check("t4_rd_new", rd_data, 11);
    check("t4_fvalid_drop", fvalid, 0);

    // 5: gappy valid, junk on idle cycles must be ignored
    do_reset();
    begin
      logic [7:0] pat;
      int         sent;
      pat  = 8'b1011_0110;
      sent = 0;
      for (int k = 0; k < 64 && sent < 6; k++) begin
        valid = pat[k % 8];
        data  = valid ? DW'(100 + sent) : DW'(32'hFFFF);
        last  = valid ? (sent == 5) : 1'b1;
        @(negedge clk);
        if (valid) sent++;
      end
      valid = 1'b0;
      check("t5_beats", sent, 6);
    end
    check("t5_fvalid", fvalid, 1);
    check("t5_pval", pval, 105);
    check("t5_pbin", pbin, 5);
    check("t5_len", flen, 6);
    check("t5_count", fcount, 1);
    for (int a = 0; a < 6; a++) begin
      rd_addr = AW'(a);
      @(negedge clk);
      check("t5_rd", rd_data, 100 + a);
    end

    // 6: reset mid-frame discards the partial frame
    do_reset();
    send(50, 0); send(60, 0); send(70, 0);
    valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_in_rst_fvalid", fvalid, 0);
    check("t6_in_rst_count", fcount, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_after_rst_fvalid", fvalid, 0);
    send(7, 0); send(3, 1);
    valid = 1'b0;
    check("t6_fvalid", fvalid, 1);
    check("t6_count", fcount, 1);
    check("t6_len", flen, 2);
    check("t6_pbin", pbin, 0);
    check("t6_pval", pval, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
